// File: rtl/sr_crypto_sequencer.sv
// Crypto sequencer: issues one scalar-crypto op to a variable-latency
// core over valid/ready, stalls decode while busy, then writes the RF.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   crypt_instr         decoder flags current instruction as crypto
//   crypt_mode[20:0]    one-hot crypto mode
//   rs1_val, rs2_val    operands
//   rd_addr[4:0]        destination register
//   cry_i_valid/ready   request handshake to the core
//   cry_mode/op1/op2    latched request payload
//   cry_o_valid         core result pulse
//   cry_result          core result data
//   hold                stall PC/decode
//   ctrls_select        1 = sequencer owns the RF write port
//   regWrite, wa, wd    RF write (one cycle, in WB)
//   cry_err             one-cycle pulse in WB after a watchdog abort

module sr_crypto_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crypt_instr,
  input  logic [20:0] crypt_mode,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_addr,
  output logic        cry_i_valid,
  input  logic        cry_i_ready,
  output logic [20:0] cry_mode,
  output logic [31:0] cry_op1,
  output logic [31:0] cry_op2,
  input  logic        cry_o_valid,
  input  logic [31:0] cry_result,
  output logic        hold,
  output logic        ctrls_select,
  output logic        regWrite,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic        cry_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [20:0]      mode_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic [4:0]       rd_q;
  logic [31:0]      res_q;
  logic [31:0]      res_d;
  logic             tmo_q;
  logic             tmo_d;
  logic             latch_req;

  logic is_idle;
  logic is_issue;
  logic is_wait;
  logic is_wb;

  assign is_idle  = (state_q == S_IDLE);
  assign is_issue = (state_q == S_ISSUE);
  assign is_wait  = (state_q == S_WAIT);
  assign is_wb    = (state_q == S_WB);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    tmo_d     = tmo_q;
    latch_req = 1'b0;
    unique case (1'b1)
      is_idle: begin
        if (crypt_instr) begin
          latch_req = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      is_issue: begin
        if (cry_i_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      is_wait: begin
        cnt_d = cnt_q + 1'b1;
        // A result landing on the last watchdog cycle still wins.
        if (cry_o_valid) begin
          res_d   = cry_result;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_WB;
        end
      end
      is_wb: begin
        // Same instruction still sits in decode; do not relaunch.
        tmo_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      if (latch_req) begin
        mode_q <= crypt_mode;
        op1_q  <= rs1_val;
        op2_q  <= rs2_val;
        rd_q   <= rd_addr;
      end
    end
  end

  // Stall starts in the IDLE cycle the op is seen, not one later.
  assign hold         = (is_idle & crypt_instr)
                      | is_issue | is_wait;
  assign ctrls_select = ~is_idle;
  assign regWrite     = is_wb;
  assign cry_i_valid  = is_issue;
  assign cry_err      = is_wb & tmo_q;

  assign cry_mode = mode_q;
  assign cry_op1  = op1_q;
  assign cry_op2  = op2_q;
  assign wa       = rd_q;
  assign wd       = res_q;

endmodule
